spi_sb_bridge: RTL and testbench



---
 rtl/spi_sb_bridge.sv | 164 ++++++++++++++++
 tb/tb_spi_sb_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sb_bridge.sv
// SB_SPI system-bus sequencer: runs register init, polls SPISR, moves bytes between RXDR/TXDR and two FIFOs.
// Optional ack timeout: define SPI_SB_BRIDGE_ACK_TIMEOUT_EN.
module spi_sb_bridge #(
    parameter logic [7:0] CR2_VAL     = 8'h01,
    parameter int         RX_DEPTH    = 4,
    parameter int         TX_DEPTH    = 4,
    parameter int         ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dati,
    input  logic [7:0] sb_dato,
    input  logic       sb_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       init_done,
    output logic       rx_overrun,
    output logic       bus_error
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);

    typedef enum logic [3:0] {
        INIT_CR0, INIT_CR1, INIT_CR2, INIT_BR, INIT_CSR,
        POLL_SR, WR_TXDR, RD_RXDR, GAP
    } state_t;

    state_t     state, ret_state, acc_next;
    logic [7:0] acc_adr, acc_dat;
    logic       acc_rw;

    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_rd, rx_wr;
    logic [RAW:0]   rx_cnt;
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_rd, tx_wr;
    logic [TAW:0]   tx_cnt;
    logic         rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]   tx_head;

    assign rx_push  = sb_stb && sb_ack && (state == RD_RXDR);
    assign tx_pop   = sb_stb && sb_ack && (state == WR_TXDR);
    assign rx_pop   = rx_valid && rx_ready;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = (rx_cnt != '0);
    assign rx_data  = rx_mem[rx_rd];
    assign tx_head  = tx_mem[tx_rd];
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign tx_ready = init_done && ((tx_cnt != TX_FULL) || tx_pop);

    // Address/data/direction of the access owned by the current state, and where to go after it.
    always_comb begin
        acc_adr  = 8'h00;
        acc_rw   = 1'b0;
        acc_dat  = 8'h00;
        acc_next = POLL_SR;
        case (state)
            INIT_CR0: begin acc_adr = 8'h08; acc_rw = 1'b1; acc_dat = 8'h00;   acc_next = INIT_CR1; end
            INIT_CR1: begin acc_adr = 8'h09; acc_rw = 1'b1; acc_dat = 8'h80;   acc_next = INIT_CR2; end
            INIT_CR2: begin acc_adr = 8'h0A; acc_rw = 1'b1; acc_dat = CR2_VAL; acc_next = INIT_BR;  end
            INIT_BR:  begin acc_adr = 8'h0B; acc_rw = 1'b1; acc_dat = 8'h00;   acc_next = INIT_CSR; end
            INIT_CSR: begin acc_adr = 8'h0F; acc_rw = 1'b1; acc_dat = 8'h00;   acc_next = POLL_SR;  end
            POLL_SR: begin
                acc_adr = 8'h0C;
                if (sb_dato[4] && (tx_cnt != '0))
                    acc_next = WR_TXDR;
                else if (sb_dato[3] && (rx_cnt != RX_FULL))
                    acc_next = RD_RXDR;
            end
            WR_TXDR: begin acc_adr = 8'h0D; acc_rw = 1'b1; acc_dat = tx_head; end
            RD_RXDR: acc_adr = 8'h0E;
            default: ;
        endcase
    end

`ifdef SPI_SB_BRIDGE_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT_CR0;
            ret_state  <= INIT_CR0;
            sb_stb     <= 1'b0;
            sb_rw      <= 1'b0;
            sb_adr     <= 8'h00;
            sb_dati    <= 8'h00;
            init_done  <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef SPI_SB_BRIDGE_ACK_TIMEOUT_EN
            bus_error  <= 1'b0;
            to_cnt     <= '0;
`endif
        end else if (state == GAP) begin
            state <= ret_state;
        end else if (!sb_stb) begin
            sb_stb  <= 1'b1;
            sb_adr  <= acc_adr;
            sb_rw   <= acc_rw;
            sb_dati <= acc_dat;
`ifdef SPI_SB_BRIDGE_ACK_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else if (sb_ack) begin
            sb_stb    <= 1'b0;
            state     <= GAP;
            ret_state <= acc_next;
            if (state == INIT_CSR)
                init_done <= 1'b1;
            if (state == POLL_SR && sb_dato[1])
                rx_overrun <= 1'b1;
`ifdef SPI_SB_BRIDGE_ACK_TIMEOUT_EN
            to_cnt <= '0;
        end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            // Abandon the access; an aborted init write restarts the whole sequence.
            sb_stb    <= 1'b0;
            bus_error <= 1'b1;
            state     <= GAP;
            ret_state <= init_done ? POLL_SR : INIT_CR0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rd <= '0; rx_wr <= '0; rx_cnt <= '0;
            tx_rd <= '0; tx_wr <= '0; tx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: ;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= sb_dato;
        if (tx_push) tx_mem[tx_wr] <= tx_data;
    end
endmodule

// File: tb/tb_spi_sb_bridge.sv
// Bench for spi_sb_bridge: SB_SPI bus model with random ack delays, and a queue-based model of the
// expected access order and FIFO streams checked every cycle.
module tb_spi_sb_bridge;
    localparam int RXD = 4;
    localparam int TXD = 4;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sb_stb, sb_rw, sb_ack;
    logic [7:0] sb_adr, sb_dati, sb_dato;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic       init_done, rx_overrun, bus_error;

    spi_sb_bridge dut (
        .clk(clk), .rst(rst), .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_adr(sb_adr),
        .sb_dati(sb_dati), .sb_dato(sb_dato), .sb_ack(sb_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .init_done(init_done), .rx_overrun(rx_overrun), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // bus model stimulus controls
    logic [7:0] sr_q[$], rxd_q[$];
    bit ack_rand = 0, sr_rand = 0, hold_sr = 0, hold_rxdr = 0;
    int wcnt;

    initial begin
        sb_ack = 1'b0; sb_dato = 8'h00; wcnt = -1;
        forever begin
            @(posedge clk); #1;
            if (sb_ack) begin
                sb_ack = 1'b0; sb_dato = 8'h00; wcnt = -1;
            end else if (sb_stb && !rst && !(hold_sr && sb_adr == 8'h0C) && !(hold_rxdr && sb_adr == 8'h0E)) begin
                if (wcnt < 0) wcnt = ack_rand ? int'($urandom_range(0, 3)) : 2;
                if (wcnt == 0) begin
                    sb_ack = 1'b1; wcnt = -1;
                    if (!sb_rw && sb_adr == 8'h0C) begin
                        if (sr_q.size() != 0) sb_dato = sr_q.pop_front();
                        else if (sr_rand) sb_dato = (8'($urandom) & 8'h18) | (($urandom_range(0, 15) == 0) ? 8'h02 : 8'h00);
                        else sb_dato = 8'h00;
                    end else if (!sb_rw && sb_adr == 8'h0E) begin
                        sb_dato = (rxd_q.size() != 0) ? rxd_q.pop_front() : 8'($urandom);
                    end
                end else wcnt--;
            end else wcnt = -1;
        end
    end

    // reference model: expected next register access and FIFO contents
    logic [7:0] init_adr [5] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0F};
    logic [7:0] init_dat [5] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00};
    logic [7:0] rxq[$], txq[$], popped[$], tx_log[$];
    logic [7:0] exp_adr;
    int  init_idx, n_rxrd = 0;
    bit  m_init, m_ovr, after_ack, mon_on = 0, pop_now;

    always @(negedge clk) begin
        if (rst) begin
            rxq.delete(); txq.delete();
            init_idx = 0; m_init = 0; m_ovr = 0; after_ack = 0; exp_adr = 8'h0C;
        end else if (mon_on) begin
            chk("init_done", init_done, m_init);
            chk("rx_overrun", rx_overrun, m_ovr);
            if (after_ack) chk("stb_gap", sb_stb, 1'b0);
            after_ack = 0;
            chk("rx_valid", rx_valid, rxq.size() != 0);
            if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
            pop_now = sb_stb && sb_ack && init_idx == 5 && exp_adr == 8'h0D;
            chk("tx_ready", tx_ready, m_init && (txq.size() < TXD || pop_now));
            if (sb_stb && sb_ack) begin
                after_ack = 1;
                if (init_idx < 5) begin
                    chk("init_adr", sb_adr, init_adr[init_idx]);
                    chk("init_rw", sb_rw, 1'b1);
                    chk("init_dat", sb_dati, init_dat[init_idx]);
                    init_idx++;
                    if (init_idx == 5) m_init = 1;
                end else begin
                    chk("acc_adr", sb_adr, exp_adr);
                    if (exp_adr == 8'h0C) begin
                        chk("sr_rw", sb_rw, 1'b0);
                        if (sb_dato[1]) m_ovr = 1;
                        if (sb_dato[4] && txq.size() > 0)      exp_adr = 8'h0D;
                        else if (sb_dato[3] && rxq.size() < RXD) exp_adr = 8'h0E;
                        else                                     exp_adr = 8'h0C;
                    end else if (exp_adr == 8'h0D) begin
                        chk("txdr_rw", sb_rw, 1'b1);
                        if (txq.size() > 0) begin
                            chk("txdr_dat", sb_dati, txq[0]);
                            tx_log.push_back(sb_dati);
                            void'(txq.pop_front());
                        end
                        exp_adr = 8'h0C;
                    end else begin
                        chk("rxdr_rw", sb_rw, 1'b0);
                        rxq.push_back(sb_dato);
                        n_rxrd++;
                        exp_adr = 8'h0C;
                    end
                end
            end
            if (rx_valid && rx_ready && rxq.size() != 0) popped.push_back(rxq.pop_front());
            if (tx_valid && tx_ready) txq.push_back(tx_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int i, n, s0, r0;
        rx_ready = 0; tx_valid = 0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_stb", sb_stb, 1'b0);       chk("rst_rw", sb_rw, 1'b0);
        chk("rst_adr", sb_adr, 8'h00);      chk("rst_dati", sb_dati, 8'h00);
        chk("rst_init", init_done, 1'b0);   chk("rst_ovr", rx_overrun, 1'b0);
        chk("rst_berr", bus_error, 1'b0);   chk("rst_rxv", rx_valid, 1'b0);
        chk("rst_txr", tx_ready, 1'b0);
        mon_on = 1;
        sr_q = '{8'h08, 8'h08, 8'h08};
        rxd_q = '{8'h11, 8'hA5, 8'h3C};
        step(1); rst = 0;

        // RX path: three bytes queue up, then drain in order
        for (i = 0; i < 400 && rxq.size() < 3; i++) @(negedge clk);
        chk("rx3_wait", rxq.size(), 3);
        @(negedge clk);
        chk("rx_head_valid", rx_valid, 1'b1);
        chk("rx_head", rx_data, 8'h11);
        step(1); rx_ready = 1;
        for (i = 0; i < 20 && popped.size() < 3; i++) step(1);
        rx_ready = 0;
        chk("rx_pops", popped.size(), 3);
        if (popped.size() >= 3) begin
            chk("rx_ord0", popped[0], 8'h11); chk("rx_ord1", popped[1], 8'hA5); chk("rx_ord2", popped[2], 8'h3C);
        end
        @(negedge clk); chk("rx_empty", rx_valid, 1'b0);

        // TX priority over RX
        step(1); tx_valid = 1; tx_data = 8'h40;
        step(1); tx_data = 8'h5A;
        step(1); tx_valid = 0;
        sr_q.push_back(8'h18); sr_q.push_back(8'h18);
        for (i = 0; i < 400 && tx_log.size() < 2; i++) step(1);
        chk("tx_cnt", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin chk("tx_ord0", tx_log[0], 8'h40); chk("tx_ord1", tx_log[1], 8'h5A); end

        // RX full: RXDR must not be read beyond the FIFO depth
        s0 = rxq.size(); r0 = n_rxrd;
        repeat (6) sr_q.push_back(8'h08);
        for (i = 0; i < 600 && sr_q.size() != 0; i++) step(1);
        step(20);
        chk("rx_full_occ", rxq.size(), RXD);
        chk("rx_full_reads", n_rxrd - r0, RXD - s0);

        // sticky overrun
        sr_q.push_back(8'h02);
        for (i = 0; i < 200 && sr_q.size() != 0; i++) step(1);
        step(100);
        chk("ovr_sticky", rx_overrun, 1'b1);

        // TX flow control with TRDY never set
        tx_valid = 1;
        for (i = 0; i < 5; i++) begin
            tx_data = 8'($urandom);
            @(negedge clk);
            if (i == 4) chk("tx_full", tx_ready, 1'b0);
            step(1);
        end
        tx_valid = 0;

        // randomized traffic
        sr_rand = 1; ack_rand = 1;
        for (i = 0; i < 3000; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            rx_ready = $urandom_range(0, 1);
            step(1);
        end
        tx_valid = 0; rx_ready = 1; sr_rand = 0;
        step(200);

        // reset in the middle of an RXDR read
        hold_rxdr = 1;
        repeat (4) sr_q.push_back(8'h08);
        for (i = 0; i < 1000 && !(sb_stb && sb_adr == 8'h0E); i++) @(negedge clk);
        chk("rxdr_seen", sb_stb && sb_adr == 8'h0E, 1'b1);
        #1 rst = 1;
        @(negedge clk);
        chk("rst_mid_stb", sb_stb, 1'b0);
        chk("rst_mid_rxv", rx_valid, 1'b0);
        step(1); rst = 0; hold_rxdr = 0; sr_q.delete();
        for (n = 0; n < 20 && !sb_stb; n++) @(negedge clk);
        chk("reinit_adr", sb_adr, 8'h08);
        chk("reinit_rw", sb_rw, 1'b1);
        for (i = 0; i < 200 && !m_init; i++) step(1);
        chk("reinit_done", init_done, 1'b1);

`ifdef SPI_SB_BRIDGE_ACK_TIMEOUT_EN
        hold_sr = 1;
        for (i = 0; i < 50 && sb_stb; i++) @(negedge clk);
        for (i = 0; i < 50 && !(sb_stb && sb_adr == 8'h0C); i++) @(negedge clk);
        n = 0;
        while (sb_stb && n < 200) begin n++; @(negedge clk); end
        chk("to_len", n, 64);
        chk("to_berr", bus_error, 1'b1);
        @(negedge clk); chk("to_gap", sb_stb, 1'b0);
        @(negedge clk); chk("to_repoll", sb_stb, 1'b1); chk("to_repoll_adr", sb_adr, 8'h0C);
        hold_sr = 0;
        step(20);
`else
        chk("berr_zero", bus_error, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
